// File: rtl/xe4_audio_synth.sv
// Multi-channel square-wave tone synth with a CPU register window and a stereo PWM mixer.
// Latency: register reads one cycle, writes on the same edge. Backpressure: none (CPU accesses always complete).
// Optional per-channel LFSR noise mode is enabled by defining XE4_AUDIO_NOISE_EN.
module xe4_audio_synth #(
  parameter int         NUM_CH    = 3,
  parameter int         PERIOD_W  = 13,
  parameter int         VOL_W     = 5,
  parameter logic [9:0] BASE_ADDR = 10'h004,
  parameter int         CLK_DIV   = 25,
  parameter int         TONE_DIV  = 16,
  parameter int         DUR_DIV   = 20000,
  parameter int         PWM_DIV   = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] Address,
  input  logic [7:0]  InData,
  input  logic        we,
  output logic [7:0]  OutData,
  output logic        LeftChannel,
  output logic        RightChannel
);

  localparam int MIX_W    = VOL_W + $clog2(NUM_CH + 1);
  localparam int TONE_CYC = CLK_DIV * TONE_DIV;
  localparam int DUR_CYC  = CLK_DIV * DUR_DIV;
  localparam int TONE_PW  = $clog2(TONE_CYC + 1);
  localparam int DUR_PW   = $clog2(DUR_CYC + 1);
  localparam int PWM_PW   = $clog2(PWM_DIV + 1);
  localparam logic [7:0]       PER_HI_MASK = 8'(((1 << PERIOD_W) - 1) >> 8);
  localparam logic [MIX_W-1:0] PWM_TOP     = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_PLAYING = 2'd2
  } ch_state_t;

  logic       hit;
  logic       ch_ok;
  logic       wr_en;
  logic [2:0] ch_idx;
  logic [2:0] reg_idx;

  assign hit     = (Address[15:6] == BASE_ADDR);
  assign ch_idx  = Address[5:3];
  assign reg_idx = Address[2:0];
  assign ch_ok   = (int'(ch_idx) < NUM_CH);
  assign wr_en   = hit && we && ch_ok;

  logic [7:0]       per_lo [NUM_CH];
  logic [7:0]       per_hi [NUM_CH];
  logic [7:0]       dur_lo [NUM_CH];
  logic [7:0]       dur_hi [NUM_CH];
  logic [VOL_W-1:0] vol_r  [NUM_CH];
  logic [NUM_CH-1:0] cfg_pan_l;
  logic [NUM_CH-1:0] cfg_pan_r;
`ifdef XE4_AUDIO_NOISE_EN
  logic [NUM_CH-1:0] cfg_noise;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_lo[c] <= '0;
        per_hi[c] <= '0;
        dur_lo[c] <= '0;
        dur_hi[c] <= '0;
        vol_r[c]  <= '0;
      end
      cfg_pan_l <= '0;
      cfg_pan_r <= '0;
`ifdef XE4_AUDIO_NOISE_EN
      cfg_noise <= '0;
`endif
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 3'(c)) begin
          case (reg_idx)
            3'd0: per_lo[c] <= InData;
            3'd1: per_hi[c] <= InData & PER_HI_MASK;
            3'd2: dur_lo[c] <= InData;
            3'd3: dur_hi[c] <= InData;
            3'd4: vol_r[c]  <= InData[VOL_W-1:0];
            3'd5: begin
              cfg_pan_l[c] <= InData[0];
              cfg_pan_r[c] <= InData[1];
`ifdef XE4_AUDIO_NOISE_EN
              cfg_noise[c] <= InData[2];
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Start/stop are write strobes only; they are never stored, so they read back 0.
  logic [NUM_CH-1:0] start_req;
  logic [NUM_CH-1:0] stop_req;

  always_comb begin
    start_req = '0;
    stop_req  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && ch_idx == 3'(c) && reg_idx == 3'd5) begin
        start_req[c] = InData[7];
        stop_req[c]  = InData[6];
      end
    end
  end

  logic [TONE_PW-1:0] tone_pre;
  logic [DUR_PW-1:0]  dur_pre;
  logic [PWM_PW-1:0]  pwm_pre;
  logic               tone_tick;
  logic               dur_tick;
  logic               pwm_tick;

  assign tone_tick = (tone_pre == '0);
  assign dur_tick  = (dur_pre == '0);
  assign pwm_tick  = (pwm_pre == '0);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tone_pre <= TONE_PW'(TONE_CYC - 1);
      dur_pre  <= DUR_PW'(DUR_CYC - 1);
      pwm_pre  <= PWM_PW'(PWM_DIV - 1);
    end else begin
      tone_pre <= tone_tick ? TONE_PW'(TONE_CYC - 1) : tone_pre - 1'b1;
      dur_pre  <= dur_tick  ? DUR_PW'(DUR_CYC - 1)   : dur_pre - 1'b1;
      pwm_pre  <= pwm_tick  ? PWM_PW'(PWM_DIV - 1)   : pwm_pre - 1'b1;
    end
  end

  logic [NUM_CH-1:0] ch_pend;
  logic [NUM_CH-1:0] ch_play;
  logic [NUM_CH-1:0] act_pan_l;
  logic [NUM_CH-1:0] act_pan_r;
  logic [VOL_W-1:0]  lvl [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t         state_q;
    ch_state_t         state_d;
    logic              load;
    logic              expire;
    logic              lvl_on;
    logic [PERIOD_W-1:0] cfg_per;
    logic [PERIOD_W-1:0] act_per;
    logic [PERIOD_W-1:0] tcnt;
    logic [15:0]       dcnt;
    logic [VOL_W-1:0]  act_vol;
    logic              phase;
    logic              pl_q;
    logic              pr_q;

    assign cfg_per = PERIOD_W'({per_hi[g], per_lo[g]});
    assign expire  = (state_q == ST_PLAYING) && tone_tick && (tcnt == '0);

    always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req[g]) state_d = ST_PENDING;
        end
        ST_PENDING: begin
          if (!start_req[g] && dur_tick) begin
            state_d = ST_PLAYING;
            load    = 1'b1;
          end
        end
        ST_PLAYING: begin
          if (start_req[g])                  state_d = ST_PENDING;
          else if (dur_tick && dcnt == '0)   state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // Stop overrides everything, including a start in the same write.
      if (stop_req[g]) begin
        state_d = ST_IDLE;
        load    = 1'b0;
      end
    end

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        act_per <= '0;
        tcnt    <= '0;
        dcnt    <= '0;
        act_vol <= '0;
        phase   <= 1'b0;
        pl_q    <= 1'b0;
        pr_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        if (load) begin
          act_per <= cfg_per;
          tcnt    <= cfg_per;
          dcnt    <= {dur_hi[g], dur_lo[g]};
          act_vol <= vol_r[g];
          pl_q    <= cfg_pan_l[g];
          pr_q    <= cfg_pan_r[g];
          phase   <= 1'b0;
        end else if (state_q == ST_PLAYING && state_d == ST_PLAYING) begin
          if (dur_tick) dcnt <= dcnt - 1'b1;
          if (tone_tick) begin
            if (tcnt == '0) begin
              tcnt  <= act_per;
              phase <= ~phase;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
        end else if (state_d != ST_PLAYING) begin
          phase <= 1'b0;
        end
      end
    end

`ifdef XE4_AUDIO_NOISE_EN
    logic [16:0] lfsr;
    logic        act_noise;

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        lfsr      <= 17'h1;
        act_noise <= 1'b0;
      end else begin
        if (load)   act_noise <= cfg_noise[g];
        if (expire) lfsr      <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
      end
    end

    assign lvl_on = act_noise ? lfsr[0] : phase;
`else
    assign lvl_on = phase;
`endif

    assign lvl[g]       = (state_q == ST_PLAYING && lvl_on) ? act_vol : '0;
    assign ch_pend[g]   = (state_q == ST_PENDING);
    assign ch_play[g]   = (state_q == ST_PLAYING);
    assign act_pan_l[g] = pl_q;
    assign act_pan_r[g] = pr_q;
  end

  logic [7:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 3'(c)) begin
        case (reg_idx)
          3'd0: rd_val = per_lo[c];
          3'd1: rd_val = per_hi[c];
          3'd2: rd_val = dur_lo[c];
          3'd3: rd_val = dur_hi[c];
          3'd4: rd_val = 8'(vol_r[c]);
          3'd5: begin
            rd_val = {6'b0, cfg_pan_r[c], cfg_pan_l[c]};
`ifdef XE4_AUDIO_NOISE_EN
            rd_val[2] = cfg_noise[c];
`endif
          end
          3'd6: rd_val = {6'b0, ch_play[c], ch_pend[c]};
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)            OutData <= '0;
    else if (hit && !we)  OutData <= rd_val;
  end

  logic [MIX_W-1:0] mix_l;
  logic [MIX_W-1:0] mix_r;

  always_comb begin
    mix_l = '0;
    mix_r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (act_pan_l[c]) mix_l = mix_l + MIX_W'(lvl[c]);
      if (act_pan_r[c]) mix_r = mix_r + MIX_W'(lvl[c]);
    end
  end

  // Triangle holds each endpoint for two steps so a duty D is high for 2*D steps.
  logic [MIX_W-1:0] pwm_cnt;
  logic [MIX_W-1:0] duty_l;
  logic [MIX_W-1:0] duty_r;
  logic             pwm_up;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_up  <= 1'b1;
      duty_l  <= '0;
      duty_r  <= '0;
    end else if (pwm_tick) begin
      if (pwm_up) begin
        if (pwm_cnt == PWM_TOP) begin
          pwm_up <= 1'b0;
          duty_l <= mix_l;
          duty_r <= mix_r;
        end else begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
      end else begin
        if (pwm_cnt == '0) pwm_up  <= 1'b1;
        else               pwm_cnt <= pwm_cnt - 1'b1;
      end
    end
  end

  assign LeftChannel  = (pwm_cnt < duty_l);
  assign RightChannel = (pwm_cnt < duty_r);

endmodule

// File: tb/tb_xe4_audio_synth.sv
// Directed bench for xe4_audio_synth using short dividers (tone tick every 4, duration tick every 64, PWM step every 2 cycles).
module tb_xe4_audio_synth;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [15:0] Address;
  logic [7:0]  InData;
  logic        we;
  logic [7:0]  OutData;
  logic        LeftChannel;
  logic        RightChannel;

  int checks   = 0;
  int failures = 0;
  int cyc;

  xe4_audio_synth #(
    .NUM_CH(3), .PERIOD_W(13), .VOL_W(5), .BASE_ADDR(10'h004),
    .CLK_DIV(1), .TONE_DIV(4), .DUR_DIV(64), .PWM_DIV(2)
  ) dut (
    .sysclk(sysclk), .reset(reset), .Address(Address), .InData(InData), .we(we),
    .OutData(OutData), .LeftChannel(LeftChannel), .RightChannel(RightChannel)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] addr(input int ch, input int r);
    return 16'h0100 + 16'(ch * 8 + r);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [7:0] d);
    Address = addr(ch, r);
    InData  = d;
    we      = 1'b1;
    step(1);
    we      = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [7:0] d);
    Address = addr(ch, r);
    we      = 1'b0;
    step(1);
    d = OutData;
  endtask

  logic [7:0] d;
  logic [4:0] prev_lvl;
  logic [4:0] hi_val;
  int t_play, t_idle, ntog, nl, nr;
  int tog [4];

  initial begin
    reset = 1'b1; we = 1'b0; Address = '0; InData = '0;
    step(3);
    chk("rst_outdata", OutData, 0);
    chk("rst_left", LeftChannel, 0);
    chk("rst_right", RightChannel, 0);
    reset = 1'b0;
    rd(0, 6, d); chk("rst_status0", d, 0);
    rd(0, 0, d); chk("rst_per_lo", d, 0);

    // Register access and period MSB masking (13-bit period -> 5 bits in MSB).
    wr(0, 0, 8'h03);
    wr(0, 1, 8'hFF);
    rd(0, 1, d); chk("per_hi_mask", d, 8'h1F);
    wr(0, 1, 8'h00);
    rd(0, 0, d); chk("per_lo", d, 8'h03);
    wr(0, 2, 8'h02);
    wr(0, 3, 8'h00);
    wr(0, 4, 8'd31);
    rd(0, 4, d); chk("vol", d, 31);
    wr(0, 5, 8'h83);
    rd(0, 6, d); chk("status_pending", d, 1);

    // Poll status continuously; record PLAYING/IDLE times and level toggles.
    Address = addr(0, 6);
    t_play = -1; t_idle = -1; ntog = 0; prev_lvl = '0; hi_val = '0;
    tog[0] = 0; tog[1] = 0; tog[2] = 0; tog[3] = 0;
    for (int i = 0; i < 600 && t_idle < 0; i++) begin
      step(1);
      if (t_play < 0 && OutData == 8'h02) t_play = i;
      if (t_play >= 0 && t_idle < 0 && OutData == 8'h00) t_idle = i;
      if (dut.lvl[0] != prev_lvl) begin
        if (ntog < 4) tog[ntog] = i;
        ntog++;
        if (dut.lvl[0] != 0) hi_val = dut.lvl[0];
        prev_lvl = dut.lvl[0];
      end
    end
    chk("saw_playing", t_play >= 0, 1);
    chk("play_to_idle_cycles", t_idle - t_play, 192);
    chk("toggle_interval1", tog[1] - tog[0], 16);
    chk("toggle_interval2", tog[2] - tog[1], 16);
    chk("level_high_value", hi_val, 31);
    chk("level_idle", dut.lvl[0], 0);
    rd(0, 5, d); chk("ctrl_strobes_clear", d, 8'h03);

    // Mixer: ch0 pan L vol 31, ch1 pan R vol 16, long period so both stay high.
    for (int ch = 0; ch < 2; ch++) begin
      wr(ch, 0, 8'h90);
      wr(ch, 1, 8'h01);
      wr(ch, 2, 8'hFF);
      wr(ch, 3, 8'h00);
    end
    wr(1, 4, 8'd16);
    for (int i = 0; i < 70 && (cyc % 64) != 10; i++) step(1);
    wr(0, 5, 8'h81);
    wr(1, 5, 8'h82);
    Address = addr(0, 6);
    for (int i = 0; i < 100 && OutData != 8'h02; i++) step(1);
    chk("mix_ch0_playing", OutData, 2);
    rd(1, 6, d); chk("mix_ch1_playing", d, 2);
    step(2210);
    chk("mix_lvl0_high", dut.lvl[0], 31);
    chk("mix_lvl1_high", dut.lvl[1], 16);
    nl = 0; nr = 0;
    for (int i = 0; i < 512; i++) begin
      step(1);
      if (LeftChannel)  nl++;
      if (RightChannel) nr++;
    end
    chk("left_high_cycles", nl, 124);
    chk("right_high_cycles", nr, 64);

    // Stop while playing, then stop+start together.
    wr(0, 5, 8'h40);
    chk("stop_level0", dut.lvl[0], 0);
    rd(0, 6, d); chk("stop_idle", d, 0);
    rd(1, 6, d); chk("ch1_still_playing", d, 2);
    wr(1, 5, 8'hC2);
    rd(1, 6, d); chk("stop_start_idle", d, 0);

    // Out-of-range channel, reserved register, miss hold.
    wr(5, 0, 8'h55);
    rd(5, 0, d); chk("oor_read", d, 0);
    rd(5, 6, d); chk("oor_status", d, 0);
    rd(0, 0, d); chk("no_alias_ch0", d, 8'h90);
    rd(0, 7, d); chk("reserved_r7", d, 0);
    rd(1, 4, d); chk("ch1_vol", d, 16);
    Address = 16'h0000;
    step(1);
    chk("miss_hold", OutData, 16);

    // Reset mid-note with a pending start on ch2.
    wr(0, 0, 8'h00);
    wr(0, 1, 8'h00);
    wr(0, 5, 8'h81);
    Address = addr(0, 6);
    for (int i = 0; i < 100 && OutData != 8'h02; i++) step(1);
    chk("rst_mid_playing", OutData, 2);
    step(10);
    wr(2, 5, 8'h80);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_left", LeftChannel, 0);
    chk("rst_mid_right", RightChannel, 0);
    chk("rst_mid_outdata", OutData, 0);
    chk("rst_mid_level", dut.lvl[0], 0);
    step(1);
    reset = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      rd(ch, 6, d); chk("post_rst_status", d, 0);
    end
    step(140);
    rd(2, 6, d); chk("no_pending_survives", d, 0);
    rd(0, 4, d); chk("post_rst_vol", d, 0);

`ifdef XE4_AUDIO_NOISE_EN
    begin
      logic [16:0] m;
      logic [16:0] prev;
      wr(0, 4, 8'd31);
      wr(0, 2, 8'hFF);
      wr(0, 5, 8'h85);
      m = 17'h1;
      prev = dut.g_ch[0].lfsr;
      chk("lfsr_seed", prev, 17'h1);
      for (int k = 0; k < 100; k++) begin
        for (int i = 0; i < 200 && dut.g_ch[0].lfsr == prev; i++) step(1);
        m = {m[15:0], m[16] ^ m[13]};
        chk("lfsr_step", dut.g_ch[0].lfsr, m);
        prev = dut.g_ch[0].lfsr;
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
